// File: rtl/bike_direction_ctrl_pkg.sv
// rtl/bike_direction_ctrl_pkg.sv - shared direction codes, states and delta helpers
package bike_direction_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int DEF_SCREEN_W = 640;

  // Opposite pairs differ only in bit 1 (UP/DOWN, LEFT/RIGHT).
  function automatic dir_t dir_opposite(dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  // Per-tick pixel-address delta for a heading on a row-major framebuffer.
  function automatic logic [31:0] dir_delta(dir_t d, int sw);
    case (d)
      DIR_UP:   return 32'(-sw);
      DIR_LEFT: return 32'hFFFF_FFFF;
      DIR_DOWN: return 32'(sw);
      default:  return 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/bike_direction_ctrl_if.sv
// rtl/bike_direction_ctrl_if.sv - button/event inputs and steering outputs bundle
interface bike_direction_ctrl_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        start;
  logic        crash;
  logic        game_tick;
  logic [31:0] move_delta;
  logic [1:0]  heading;
  logic        alive;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, start, crash, game_tick,
    input  move_delta, heading, alive
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, start, crash, game_tick,
    output move_delta, heading, alive
  );
endinterface

// File: rtl/bike_direction_ctrl_btn_debounce.sv
// rtl/bike_direction_ctrl_btn_debounce.sv - synchronizer, stability counter and press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_prev_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Level flips only after the synced value has disagreed for the full window.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else if (sync2_q == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      level_q <= sync2_q;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered one-cycle pulse on the debounced rising edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/bike_direction_ctrl.sv
// rtl/bike_direction_ctrl.sv - per-player steering: debounce, pending turn, tick-committed heading
module bike_direction_ctrl
  import bike_direction_ctrl_pkg::*;
#(
  parameter int         SCREEN_W        = DEF_SCREEN_W,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [1:0] INIT_DIR        = 2'd3
) (
  input  logic                 clock,
  input  logic                 resetn,
  bike_direction_ctrl_if.slave bus
);
  localparam dir_t INIT_HEADING = dir_t'(INIT_DIR);

  logic press_up, press_down, press_left, press_right;
  logic req_valid;
  dir_t req_dir;

  logic   pend_valid_q, pend_valid_d;
  dir_t   pend_dir_q, pend_dir_d;
  state_t state_q;
  dir_t   heading_q, heading_d;
  logic [31:0] delta_q;
  logic   alive_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clock(clock), .resetn(resetn), .btn_i(bus.btn_up), .press_o(press_up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clock(clock), .resetn(resetn), .btn_i(bus.btn_down), .press_o(press_down));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clock(clock), .resetn(resetn), .btn_i(bus.btn_left), .press_o(press_left));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clock(clock), .resetn(resetn), .btn_i(bus.btn_right), .press_o(press_right));

  // Collapse simultaneous presses to one request, UP > DOWN > LEFT > RIGHT.
  always_comb begin
    req_valid = press_up | press_down | press_left | press_right;
    req_dir   = DIR_RIGHT;
    if (press_up)        req_dir = DIR_UP;
    else if (press_down) req_dir = DIR_DOWN;
    else if (press_left) req_dir = DIR_LEFT;
  end

  // Pending request: last press wins; a press on the tick cycle survives for the next tick.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    if (bus.start || (state_q == RUN && bus.crash)) begin
      pend_valid_d = 1'b0;
    end else if (state_q == RUN && req_valid) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = req_dir;
    end else if (state_q == RUN && bus.game_tick) begin
      pend_valid_d = 1'b0;
    end
  end

  // Pending request register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_UP;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
    end
  end

  // Reversal and no-op turns are judged against the heading at tick time.
  always_comb begin
    heading_d = heading_q;
    if (pend_valid_q && pend_dir_q != heading_q && pend_dir_q != dir_opposite(heading_q))
      heading_d = pend_dir_q;
  end

  // Round FSM with registered heading, delta and alive; start outranks crash, crash outranks tick.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      heading_q <= INIT_HEADING;
      delta_q   <= '0;
      alive_q   <= 1'b0;
    end else if (bus.start) begin
      state_q   <= RUN;
      heading_q <= INIT_HEADING;
      delta_q   <= dir_delta(INIT_HEADING, SCREEN_W);
      alive_q   <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.crash) begin
            state_q <= DEAD;
            delta_q <= '0;
            alive_q <= 1'b0;
          end else if (bus.game_tick) begin
            heading_q <= heading_d;
            delta_q   <= dir_delta(heading_d, SCREEN_W);
          end
        end
        default: begin
          delta_q <= '0;
          alive_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.move_delta = delta_q;
  assign bus.heading    = heading_q;
  assign bus.alive      = alive_q;
endmodule

// File: tb/tb_bike_direction_ctrl.sv
// tb/tb_bike_direction_ctrl.sv - table plus sequence bench with expectation scoreboard
module tb_bike_direction_ctrl;

  localparam logic [31:0] D_UP    = 32'hFFFF_FD80;
  localparam logic [31:0] D_LEFT  = 32'hFFFF_FFFF;
  localparam logic [31:0] D_DOWN  = 32'd640;
  localparam logic [31:0] D_RIGHT = 32'd1;

  logic clock;
  logic resetn;
  bike_direction_ctrl_if bus ();

  bike_direction_ctrl #(.SCREEN_W(640), .DEBOUNCE_CYCLES(16), .INIT_DIR(2'd3)) dut (
    .clock(clock), .resetn(resetn), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] delta;
    logic [1:0]  head;
    logic        alive;
  } exp_t;

  typedef struct {
    string       name;
    logic        start;
    logic        crash;
    logic        tick;
    logic [31:0] delta;
    logic [1:0]  head;
    logic        alive;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int checks = 0;
  int failures = 0;

  task automatic push_exp(input string n, input logic [31:0] d, input logic [1:0] h, input logic a);
    exp_t e;
    e.name = n; e.delta = d; e.head = h; e.alive = a;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (bus.move_delta !== e.delta || bus.heading !== e.head || bus.alive !== e.alive) begin
      failures++;
      $display("FAIL %s: got delta=%h heading=%0d alive=%0b, want delta=%h heading=%0d alive=%0b",
               e.name, bus.move_delta, bus.heading, bus.alive, e.delta, e.head, e.alive);
    end
  endtask

  // One clock with given event inputs; outputs checked #1 after the edge.
  task automatic cyc(input string n, input logic st, input logic cr, input logic tk,
                     input logic [31:0] d, input logic [1:0] h, input logic a);
    bus.start = st; bus.crash = cr; bus.game_tick = tk;
    push_exp(n, d, h, a);
    @(posedge clock);
    #1;
    pop_check();
    bus.start = 1'b0; bus.crash = 1'b0; bus.game_tick = 1'b0;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: bus.btn_up = v;
      1: bus.btn_left = v;
      2: bus.btn_down = v;
      default: bus.btn_right = v;
    endcase
  endtask

  // Hold a button long enough to register a press, release, and let the release settle.
  task automatic press(input string n, input int idx, input logic [31:0] d, input logic [1:0] h);
    set_btn(idx, 1'b1);
    for (int i = 0; i < 20; i++) cyc(n, 0, 0, 0, d, h, 1);
    set_btn(idx, 1'b0);
    for (int i = 0; i < 22; i++) cyc(n, 0, 0, 0, d, h, 1);
  endtask

  initial begin
    resetn = 1'b0;
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    bus.start = 0; bus.crash = 0; bus.game_tick = 0;

    vecs[0] = '{"idle_tick_ignored", 0, 0, 1, 32'd0,   2'd3, 0};
    vecs[1] = '{"start_run",         1, 0, 0, D_RIGHT, 2'd3, 1};
    vecs[2] = '{"tick1_straight",    0, 0, 1, D_RIGHT, 2'd3, 1};
    vecs[3] = '{"tick2_straight",    0, 0, 1, D_RIGHT, 2'd3, 1};
    vecs[4] = '{"tick3_straight",    0, 0, 1, D_RIGHT, 2'd3, 1};
    vecs[5] = '{"crash_dead",        0, 1, 0, 32'd0,   2'd3, 0};
    vecs[6] = '{"dead_tick",         0, 0, 1, 32'd0,   2'd3, 0};
    vecs[7] = '{"start_beats_crash", 1, 1, 1, D_RIGHT, 2'd3, 1};

    repeat (3) @(posedge clock);
    #1;
    push_exp("reset_state", 32'd0, 2'd3, 0);
    pop_check();
    resetn = 1'b1;

    for (int i = 0; i < 8; i++)
      cyc(vecs[i].name, vecs[i].start, vecs[i].crash, vecs[i].tick,
          vecs[i].delta, vecs[i].head, vecs[i].alive);

    // Bouncing DOWN never stays stable for the debounce window.
    for (int i = 0; i < 100; i++) begin
      if (i % 5 == 0) bus.btn_down = ~bus.btn_down;
      cyc("bounce_hold", 0, 0, 0, D_RIGHT, 2'd3, 1);
    end
    bus.btn_down = 1'b0;
    for (int i = 0; i < 22; i++) cyc("bounce_settle", 0, 0, 0, D_RIGHT, 2'd3, 1);
    cyc("bounce_tick", 0, 0, 1, D_RIGHT, 2'd3, 1);

    // Turn UP, committed only on the tick.
    press("up_before_tick", 0, D_RIGHT, 2'd3);
    cyc("up_tick", 0, 0, 1, D_UP, 2'd0, 1);
    press("right_pending", 3, D_UP, 2'd0);
    cyc("right_tick", 0, 0, 1, D_RIGHT, 2'd3, 1);

    // LEFT from RIGHT is a reversal.
    press("left_pending", 1, D_RIGHT, 2'd3);
    cyc("left_reversal", 0, 0, 1, D_RIGHT, 2'd3, 1);

    // UP then LEFT before a tick: LEFT wins and is rejected; pending cleared afterwards.
    press("up_then", 0, D_RIGHT, 2'd3);
    press("left_last", 1, D_RIGHT, 2'd3);
    cyc("last_wins_reject", 0, 0, 1, D_RIGHT, 2'd3, 1);
    cyc("pending_cleared", 0, 0, 1, D_RIGHT, 2'd3, 1);

    // Pending DOWN is dropped by crash on the same cycle as the tick.
    press("down_pending", 2, D_RIGHT, 2'd3);
    cyc("crash_and_tick", 0, 1, 1, 32'd0, 2'd3, 0);
    cyc("dead_hold", 0, 0, 1, 32'd0, 2'd3, 0);
    cyc("restart", 1, 0, 0, D_RIGHT, 2'd3, 1);
    cyc("restart_no_stale", 0, 0, 1, D_RIGHT, 2'd3, 1);

    press("down_again", 2, D_RIGHT, 2'd3);
    cyc("down_tick", 0, 0, 1, D_DOWN, 2'd2, 1);

    // Press pulse lands on the tick cycle: applied only on the following tick.
    bus.btn_left = 1'b1;
    for (int i = 0; i < 19; i++) cyc("left_ramp", 0, 0, 0, D_DOWN, 2'd2, 1);
    cyc("press_on_tick", 0, 0, 1, D_DOWN, 2'd2, 1);
    bus.btn_left = 1'b0;
    for (int i = 0; i < 22; i++) cyc("left_release", 0, 0, 0, D_DOWN, 2'd2, 1);
    cyc("deferred_left", 0, 0, 1, D_LEFT, 2'd1, 1);

    // Asynchronous reset mid-round.
    #2;
    resetn = 1'b0;
    #1;
    push_exp("async_reset", 32'd0, 2'd3, 0);
    pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
